// File: rtl/mem_stage_dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int unsigned DMEM_DEPTH_DEF   = 256;
  localparam int unsigned DMEM_LATENCY_DEF = 2;

  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_stage_dmem_array.sv
// Single-port synchronous word RAM: one write enable, registered read, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH_DEF,
  parameter int unsigned AW    = idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Read register only moves on an explicit read so the last load result is held.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage_dmem.sv
// MEM-stage multi-cycle data memory responder: stalls the pipeline for LATENCY+1
// cycles per access. Optional misalignment check under DMEM_ALIGN_CHECK_EN.
module mem_stage_dmem
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = DMEM_DEPTH_DEF,
  parameter int unsigned LATENCY = DMEM_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic [31:0] ALUResult_MEM,
  input  logic [31:0] ForwardBOut_MEM,
  output logic [31:0] ReadData_MEM,
  output logic        MemStall,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic        MemError,
`endif
  output logic        MemDone
);

  localparam int unsigned AW = idx_width(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  dmem_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic          r_rd;
  logic          r_wr;
  logic          r_mis;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_done;
  logic          r_rzero;
`ifdef DMEM_ALIGN_CHECK_EN
  logic          r_err;
`endif

  logic          w_req;
  logic          w_fire;
  logic          w_mis_req;
  logic          w_we;
  logic          w_re;
  logic [31:0]   w_rdata;
  logic          w_unused_addr;

  assign w_req  = MemRead_MEM | MemWrite_MEM;
  assign w_fire = (r_state == BUSY) && (r_cnt == '0);

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_mis_req = |ALUResult_MEM[1:0];
`else
  assign w_mis_req = 1'b0;
`endif
  assign w_unused_addr = &{1'b0, ALUResult_MEM[31:AW+2], ALUResult_MEM[1:0]};

  always_comb begin
    MemStall = 1'b0;
    if (!reset)
      MemStall = ((r_state == IDLE) && w_req) || (r_state == BUSY);
  end

  // A read-with-write behaves as a pure store; misaligned accesses never touch the array.
  assign w_we = w_fire && r_wr && !r_mis && !reset;
  assign w_re = w_fire && r_rd && !r_wr && !r_mis && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_mis   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_rzero <= 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
          r_err  <= 1'b0;
`endif
          if (w_req) begin
            r_rd    <= MemRead_MEM;
            r_wr    <= MemWrite_MEM;
            r_mis   <= w_mis_req;
            r_addr  <= ALUResult_MEM[AW+1:2];
            r_wdata <= ForwardBOut_MEM;
            r_cnt   <= CNT_INIT;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_done  <= 1'b1;
            r_state <= DONE;
`ifdef DMEM_ALIGN_CHECK_EN
            r_err   <= r_mis;
`endif
            if (r_mis)
              r_rzero <= 1'b1;
            else if (r_rd && !r_wr)
              r_rzero <= 1'b0;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
          r_err   <= 1'b0;
`endif
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  // Array read register has no reset; r_rzero supplies the zero after reset/misalign.
  assign ReadData_MEM = r_rzero ? '0 : w_rdata;
  assign MemDone      = r_done;
`ifdef DMEM_ALIGN_CHECK_EN
  assign MemError     = r_err;
`endif

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Self-checking bench for mem_stage_dmem against a word-array reference model.
module tb_mem_stage_dmem;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_MEM, MemWrite_MEM;
  logic [31:0] ALUResult_MEM, ForwardBOut_MEM;
  logic [31:0] ReadData_MEM;
  logic        MemStall, MemDone;
  logic        err_obs;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        MemError;
  assign err_obs = MemError;
`else
  assign err_obs = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_last;
  bit          m_last_known;

  always #5 clk = ~clk;

  mem_stage_dmem #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .MemRead_MEM     (MemRead_MEM),
    .MemWrite_MEM    (MemWrite_MEM),
    .ALUResult_MEM   (ALUResult_MEM),
    .ForwardBOut_MEM (ForwardBOut_MEM),
    .ReadData_MEM    (ReadData_MEM),
    .MemStall        (MemStall),
`ifdef DMEM_ALIGN_CHECK_EN
    .MemError        (MemError),
`endif
    .MemDone         (MemDone)
  );

  task automatic idle_inputs();
    MemRead_MEM     = 1'b0;
    MemWrite_MEM    = 1'b0;
    ALUResult_MEM   = $urandom;
    ForwardBOut_MEM = $urandom;
  endtask

  // Presents one access (called just after a posedge), holds it while stalled,
  // checks stall length, done pulse, error flag and load result against the model.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input string name);
    int          stalls;
    bit          finished;
    int unsigned idx;
    bit          mis;
    logic [31:0] exp_rd;
    bit          exp_known;
    idx = (addr >> 2) % DEPTH;
    mis = ALIGN && (addr[1:0] != 2'b00);
    if (mis) begin
      exp_rd = 32'h0; exp_known = 1'b1;
    end else if (wr) begin
      m_mem[idx] = data; m_known[idx] = 1'b1;
      exp_rd = m_last; exp_known = m_last_known;
    end else begin
      exp_rd = m_mem[idx]; exp_known = m_known[idx];
    end
    m_last = exp_rd; m_last_known = exp_known;

    MemRead_MEM = rd; MemWrite_MEM = wr;
    ALUResult_MEM = addr; ForwardBOut_MEM = data;
    stalls = 0; finished = 1'b0;
    for (int c = 0; c < 50 && !finished; c++) begin
      @(negedge clk);
      if (MemDone === 1'b1) begin
        finished = 1'b1;
        total++;
        if (MemStall !== 1'b0) begin
          $display("FAIL %s stall_in_done got=%b want=0", name, MemStall); bad++;
        end
        total++;
        if (stalls != LATENCY + 1) begin
          $display("FAIL %s stall_cycles got=%0d want=%0d", name, stalls, LATENCY + 1); bad++;
        end
        total++;
        if (err_obs !== mis) begin
          $display("FAIL %s err got=%b want=%b", name, err_obs, mis); bad++;
        end
        if (exp_known) begin
          total++;
          if (ReadData_MEM !== exp_rd) begin
            $display("FAIL %s rdata got=%h want=%h", name, ReadData_MEM, exp_rd); bad++;
          end
        end
      end else if (MemStall === 1'b1) begin
        stalls++;
        if (err_obs !== 1'b0) begin
          total++; bad++;
          $display("FAIL %s err_early got=%b want=0", name, err_obs);
        end
      end else begin
        total++; bad++;
        $display("FAIL %s no_stall_no_done cycle=%0d got stall=%b done=%b want stall=1",
                 name, c, MemStall, MemDone);
        finished = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!finished) begin
      total++; bad++;
      $display("FAIL %s timeout got=no_done want=done", name);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    MemRead_MEM = 1'b1; MemWrite_MEM = 1'b0;
    ALUResult_MEM = 32'h10; ForwardBOut_MEM = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (MemStall !== 1'b0) begin
      $display("FAIL reset_stall got=%b want=0", MemStall); bad++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    total++;
    if (ReadData_MEM !== 32'h0) begin
      $display("FAIL reset_rdata got=%h want=0", ReadData_MEM); bad++;
    end
    total++;
    if (MemDone !== 1'b0 || MemStall !== 1'b0 || err_obs !== 1'b0) begin
      $display("FAIL reset_flags got done=%b stall=%b err=%b want 0 0 0",
               MemDone, MemStall, err_obs); bad++;
    end
    m_last = 32'h0; m_last_known = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "store_10");
    access(1'b1, 1'b0, 32'h10, 32'h0, "load_10");
    total++;
    if (ReadData_MEM !== 32'hDEADBEEF) begin
      $display("FAIL load_10_hold got=%h want=deadbeef", ReadData_MEM); bad++;
    end
  endtask

  task automatic test_nonmem();
    for (int c = 0; c < 20; c++) begin
      idle_inputs();
      @(negedge clk);
      total++;
      if (MemStall !== 1'b0 || MemDone !== 1'b0) begin
        $display("FAIL nonmem cycle=%0d got stall=%b done=%b want 0 0", c, MemStall, MemDone);
        bad++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    access(1'b0, 1'b1, 32'h20, 32'h1, "pre_20");
    access(1'b0, 1'b1, 32'h24, 32'h2, "pre_24");
    access(1'b1, 1'b0, 32'h20, 32'h0, "b2b_20");
    access(1'b1, 1'b0, 32'h24, 32'h0, "b2b_24");
  endtask

  task automatic test_wrap();
    access(1'b0, 1'b1, 32'h400, 32'hA5, "wrap_store");
    access(1'b1, 1'b0, 32'h0, 32'h0, "wrap_load");
  endtask

  task automatic test_reset_abort();
    access(1'b0, 1'b1, 32'h8, 32'h1234_5678, "abort_pre");
    MemRead_MEM = 1'b0; MemWrite_MEM = 1'b1;
    ALUResult_MEM = 32'h8; ForwardBOut_MEM = 32'h55;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (MemStall !== 1'b0) begin
      $display("FAIL abort_reset_stall got=%b want=0", MemStall); bad++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    m_last = 32'h0; m_last_known = 1'b1;
    @(negedge clk);
    total++;
    if (MemStall !== 1'b0 || MemDone !== 1'b0) begin
      $display("FAIL abort_idle got stall=%b done=%b want 0 0", MemStall, MemDone); bad++;
    end
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h8, 32'h0, "abort_load");
  endtask

  task automatic test_misalign();
    access(1'b1, 1'b0, 32'h13, 32'h0, "mis_load");
    access(1'b1, 1'b0, 32'h10, 32'h0, "mis_after");
  endtask

  task automatic test_random();
    for (int w = 0; w < 16; w++)
      access(1'b0, 1'b1, 32'(w) << 2, $urandom, "rnd_pre");
    for (int n = 0; n < 40; n++) begin
      int unsigned op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2)
         | 32'($urandom_range(0, 3));
      access(op != 1, op != 0, a, $urandom, "rnd");
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    m_last = 32'h0; m_last_known = 1'b0;
    reset = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_store_load();
    test_nonmem();
    test_back_to_back();
    test_wrap();
    test_reset_abort();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_dmem.md
# mem_stage_dmem

Multi-cycle data-memory responder for the MEM stage of the pipelined MIPS core. It services the load/store requests that the EX/MEM pipeline register presents on its MEM-side outputs. It holds the pipeline with a stall while an access of configurable latency completes. It then returns load data for the MEM/WB register.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit words in the array; power of two, ≥4.
- LATENCY, 2, number of BUSY cycles per access; ≥1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset; sampled on posedge clk.
- MemRead_MEM  input  1  load request for the instruction currently in MEM.
- MemWrite_MEM  input  1  store request for the instruction currently in MEM.
- ALUResult_MEM  input  32  byte address.
- ForwardBOut_MEM  input  32  store data.
- ReadData_MEM  output  32  load result; registered; valid when MemDone is high.
- MemStall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM; insert bubble into MEM/WB.
- MemDone  output  1  one-cycle pulse; the access has completed and the pipeline advances this cycle.
- MemError  output  1  one-cycle misalignment pulse; present only with DMEM_ALIGN_CHECK_EN.

## Operation
- FSM has three states: IDLE, BUSY, DONE.
- IDLE, no request: stays in IDLE; MemStall=0.
- IDLE with MemRead_MEM|MemWrite_MEM:
  - MemStall=1 combinationally in the same cycle.
  - At the edge: latch op, address and data; load cnt=LATENCY-1; go to BUSY.
- BUSY: MemStall=1.
  - cnt≠0: decrement cnt.
  - cnt==0: perform the array access at the edge and go to DONE.
  - Access: a store writes the word; a load registers the word into ReadData_MEM.
- DONE: MemStall=0, MemDone=1.
  - Inputs are ignored, because they still show the just-completed instruction.
  - Next state is IDLE unconditionally.
- Word index = ALUResult_MEM[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH words.
- Read and write asserted together: the write is performed; ReadData_MEM keeps its previous value.
- A store does not change ReadData_MEM.
- Back-to-back memory instructions: DONE→IDLE, then the new request is detected in IDLE. There is no overlap.

## Timing
- Request first visible in IDLE at cycle T:
  - MemStall is high for cycles T..T+LATENCY, i.e. LATENCY+1 cycles.
  - DONE occurs at cycle T+LATENCY+1.
  - ReadData_MEM is valid from T+LATENCY+1 and holds until the next completed load.
- Non-memory instruction: zero stall cycles.
- Reset values:
  - state = IDLE.
  - ReadData_MEM = 0.
  - MemDone = 0.
  - MemError = 0.
  - cnt = 0.
  - MemStall = 0 during the reset cycle.
  - Array contents are not cleared.
- Reset asserted in BUSY or DONE: the access is abandoned, no write occurs, and the FSM returns to IDLE on the next edge.
- Reset and a request in the same cycle: reset wins; MemStall is forced to 0.

## Configuration
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - ALUResult_MEM[1:0]≠0 on a request still stalls LATENCY+1 cycles.
  - No array access is performed.
  - ReadData_MEM is set to 0.
  - MemError pulses with MemDone.
- Undefined:
  - MemError port is absent.
  - ALUResult_MEM[1:0] is ignored; a misaligned access hits the containing word.

## Structure
- Package dmem_pkg holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the default DEPTH and LATENCY constants;
  - an index-width function, log2(DEPTH).
- Sub-module dmem_array: single-port synchronous RAM with one write enable, a registered read output and no reset.
- mem_stage_dmem owns the FSM, counter, latches and stall/done/error logic.

## Test plan
- LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10.
  - Each access: MemStall high for 3 cycles; MemDone pulses on the 4th.
  - Load returns 0xDEADBEEF.
- Non-memory instruction stream: MemStall stays 0 and MemDone stays 0 for 20 cycles.
- Back-to-back loads from 0x20 and 0x24 (preloaded 0x1, 0x2): two separate 3-cycle stalls separated by one DONE cycle; results 0x1 then 0x2.
- DEPTH=256: store 0xA5 to 0x400, which wraps to index 0; then load 0x0 → 0xA5.
- Reset asserted in the 2nd BUSY cycle of a store of 0x55 to 0x8:
  - the next cycle is IDLE with MemStall=0;
  - a subsequent load of 0x8 returns the old contents.
- With DMEM_ALIGN_CHECK_EN, load 0x13:
  - 3 stall cycles;
  - MemError and MemDone pulse together;
  - ReadData_MEM = 0 and memory is unchanged.
